// File: rtl/vip_rgb888_raw8.sv
// ---------------------------------------------------------------------------
// vip_rgb888_raw8
// Turns an RGB888 video stream into an 8-bit Bayer mosaic stream. Each
// accepted pixel is reduced to one colour byte, picked from its row/column
// parity and the configured Bayer phase. Sync and strobe signals are delayed
// by one clock so they stay aligned with the sample.
// The block also counts pixels per line and lines per frame. A one-cycle
// error pulse reports any line or frame whose size differs from the
// configured geometry.
// ---------------------------------------------------------------------------
module vip_rgb888_raw8 #(
   parameter int IMG_HDISP     = 640,
   parameter int IMG_VDISP     = 480,
   parameter int BAYER_PATTERN = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   input  logic [23:0] per_img_rgb888,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic [7:0]  post_img_RAW,
   output logic        line_len_err,
   output logic        frame_len_err
);

   // Geometry and Bayer phase narrowed to the counter / parity widths.
   localparam logic [11:0] LP_HDISP   = 12'(IMG_HDISP);
   localparam logic [11:0] LP_VDISP   = 12'(IMG_VDISP);
   localparam logic [11:0] LP_CNT_MAX = 12'hFFF;
   localparam logic [1:0]  LP_PAT     = 2'(BAYER_PATTERN);

   // Previous-cycle copies of the sync inputs, used for edge detection.
   logic        r_vsync_d;
   logic        r_href_d;

   // Position of the next accepted pixel inside the frame.
   logic [11:0] r_col;
   logic [11:0] r_row;

   // Set once a frame start has been seen. Until then, size checks are
   // meaningless.
   logic        r_armed;

   // Registered outputs.
   logic        r_post_vsync;
   logic        r_post_href;
   logic        r_post_clken;
   logic [7:0]  r_post_raw;
   logic        r_line_err;
   logic        r_frame_err;

   // Combinational helpers.
   logic        w_pix_accept;
   logic        w_vsync_rise;
   logic        w_href_fall;
   logic        w_row_par;
   logic        w_col_par;
   logic [7:0]  w_lane [3];
   logic [7:0]  w_raw_sel;

   // A pixel counts only when the strobe falls inside an active line.
   assign w_pix_accept = per_frame_clken & per_frame_href;

   // Frame start and line end are both taken from the live input against
   // its registered copy.
   assign w_vsync_rise = per_frame_vsync & ~r_vsync_d;
   assign w_href_fall  = r_href_d & ~per_frame_href;

   // The Bayer phase flips the parity of the row and/or column. After that,
   // the R/G/B choice is the same for every pattern.
   assign w_row_par = r_row[0] ^ LP_PAT[1];
   assign w_col_par = r_col[0] ^ LP_PAT[0];

   // Split the input word into its byte lanes: 0 = B, 1 = G, 2 = R.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign w_lane[gi] = per_img_rgb888[gi*8 +: 8];
      end
   endgenerate

   // Pick the colour for the current mosaic site. Even/even is red,
   // odd/odd is blue, and the two mixed sites are green.
   always_comb begin
      w_raw_sel = w_lane[1];
      case ({w_row_par, w_col_par})
         2'b00:   w_raw_sel = w_lane[2];
         2'b11:   w_raw_sel = w_lane[0];
         default: w_raw_sel = w_lane[1];
      endcase
   end

   // Keep last-cycle copies of vsync and href for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsync_d <= 1'b0;
         r_href_d  <= 1'b0;
      end else begin
         r_vsync_d <= per_frame_vsync;
         r_href_d  <= per_frame_href;
      end
   end

   // Column counter. It restarts at each line end and each frame start, and
   // saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= 12'd0;
      end else if (w_vsync_rise || w_href_fall) begin
         r_col <= 12'd0;
      end else if (w_pix_accept && (r_col != LP_CNT_MAX)) begin
         r_col <= r_col + 12'd1;
      end
   end

   // Row counter. It advances on each line end, restarts at frame start and
   // saturates. Frame start wins if both events land in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= 12'd0;
      end else if (w_vsync_rise) begin
         r_row <= 12'd0;
      end else if (w_href_fall && (r_row != LP_CNT_MAX)) begin
         r_row <= r_row + 12'd1;
      end
   end

   // Arm the size checks on the first frame start after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_armed <= 1'b0;
      end else if (w_vsync_rise) begin
         r_armed <= 1'b1;
      end
   end

   // Line-length check, one cycle after href falls. It is skipped when a
   // frame start lands on the same cycle, since that restart already
   // discards the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_line_err <= 1'b0;
      end else begin
         r_line_err <= r_armed & w_href_fall & ~w_vsync_rise &
                       (r_col != LP_HDISP);
      end
   end

   // Frame-length check, one cycle after vsync rises. It uses the row count
   // as it stood before any coincident line end. r_armed is still clear on
   // the first frame start, so that start never reports.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= r_armed & w_vsync_rise & (r_row != LP_VDISP);
      end
   end

   // Sync/strobe pipeline stage. It is one clock deep, matching the sample
   // path.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_post_vsync <= 1'b0;
         r_post_href  <= 1'b0;
         r_post_clken <= 1'b0;
      end else begin
         r_post_vsync <= per_frame_vsync;
         r_post_href  <= per_frame_href;
         r_post_clken <= w_pix_accept;
      end
   end

   // Sample register. It loads only on accepted pixels and otherwise holds
   // the last mosaic byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_post_raw <= 8'h00;
      end else if (w_pix_accept) begin
         r_post_raw <= w_raw_sel;
      end
   end

   assign post_frame_vsync = r_post_vsync;
   assign post_frame_href  = r_post_href;
   assign post_frame_clken = r_post_clken;
   assign post_img_RAW     = r_post_raw;
   assign line_len_err     = r_line_err;
   assign frame_len_err    = r_frame_err;

endmodule

// File: tb/tb_vip_rgb888_raw8.sv
// ---------------------------------------------------------------------------
// Bench for vip_rgb888_raw8. Two instances (RGGB and BGGR) share one stimulus
// stream. The driver tracks each pixel's frame position and pushes the
// expected mosaic byte and error-pulse cycles into queues. A separate
// negedge monitor compares the DUT outputs against those queues and against
// last cycle's inputs.
// ---------------------------------------------------------------------------
module tb_vip_rgb888_raw8;

   localparam int H = 10;
   localparam int V = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vs  = 1'b0;
   logic        hs  = 1'b0;
   logic        ck  = 1'b0;
   logic [23:0] px  = 24'h0;

   logic        p0_vs, p0_hs, p0_ck, p0_le, p0_fe;
   logic [7:0]  p0_raw;
   logic        p3_vs, p3_hs, p3_ck, p3_le, p3_fe;
   logic [7:0]  p3_raw;

   vip_rgb888_raw8 #(.IMG_HDISP(H), .IMG_VDISP(V), .BAYER_PATTERN(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck),
      .per_img_rgb888(px),
      .post_frame_vsync(p0_vs), .post_frame_href(p0_hs), .post_frame_clken(p0_ck),
      .post_img_RAW(p0_raw), .line_len_err(p0_le), .frame_len_err(p0_fe)
   );

   vip_rgb888_raw8 #(.IMG_HDISP(H), .IMG_VDISP(V), .BAYER_PATTERN(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ck),
      .per_img_rgb888(px),
      .post_frame_vsync(p3_vs), .post_frame_href(p3_hs), .post_frame_clken(p3_ck),
      .post_img_RAW(p3_raw), .line_len_err(p3_le), .frame_len_err(p3_fe)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int errors = 0;
   int checks = 0;

   logic [7:0] q0 [$];
   logic [7:0] q3 [$];
   int         le_q [$];
   int         fe_q [$];

   // Reference model state: where the next pixel sits in the frame.
   int m_row = 0;
   int m_col = 0;
   bit m_armed = 0;
   bit m_pvs = 0;
   bit m_phs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Mosaic rule: the pattern flips the row/column parity. Then (0,0)=R,
   // (1,1)=B, and the mixed sites are G.
   function automatic logic [7:0] exp_raw(input int pat, input int row, input int col,
                                          input logic [23:0] p);
      int rp;
      int cp;
      rp = (row % 2) ^ ((pat / 2) % 2);
      cp = (col % 2) ^ (pat % 2);
      if (rp == 0 && cp == 0) return p[23:16];
      else if (rp == 1 && cp == 1) return p[7:0];
      else return p[15:8];
   endfunction

   // Drive one cycle of input and update the model. These inputs are sampled
   // at the next posedge, and their results show at the negedge after that.
   task automatic step(input bit r, input bit v, input bit h, input bit c, input logic [23:0] p);
      @(posedge clk);
      #1;
      rst = r; vs = v; hs = h; ck = c; px = p;
      if (r) begin
         m_row = 0; m_col = 0; m_armed = 0; m_pvs = 0; m_phs = 0;
      end else begin
         if (v && !m_pvs) begin
            if (m_armed && m_row != V) fe_q.push_back(cyc + 1);
            m_armed = 1; m_row = 0; m_col = 0;
         end else if (m_phs && !h) begin
            if (m_armed && m_col != H) le_q.push_back(cyc + 1);
            if (m_row < 4095) m_row++;
            m_col = 0;
         end
         if (h && c) begin
            q0.push_back(exp_raw(0, m_row, m_col, p));
            q3.push_back(exp_raw(3, m_row, m_col, p));
            if (m_col < 4095) m_col++;
         end
         m_pvs = v; m_phs = h;
      end
   endtask

   // One frame. It starts with an optional vsync pulse. The line with index
   // bad_line gets bad_len pixels, and rst_line triggers a reset at column 5
   // of that line. With merge set, the last line ends on the cycle that
   // starts the next frame's vsync.
   task automatic frame(input int id, input int nlines, input int bad_line, input int bad_len,
                        input bit formula, input bit rand_ck, input int rst_line,
                        input bit merge, input bit skip_vs);
      int n;
      int k;
      bit c;
      bit did_rst;
      logic [7:0] ra;
      logic [7:0] ga;
      logic [23:0] p;
      did_rst = 0;
      if (!skip_vs) begin
         step(0, 1, 0, 0, 24'h0);
         step(0, 1, 0, 0, 24'h0);
      end
      step(0, 0, 0, 0, 24'h0);
      step(0, 0, 0, 1, 24'h0);
      for (int l = 0; l < nlines; l++) begin
         n = (l == bad_line) ? bad_len : H;
         k = 0;
         while (k < n) begin
            if (l == rst_line && k == 5 && !did_rst) begin
               did_rst = 1;
               repeat (3) step(1, 0, 1, 1'($urandom % 2), 24'($urandom));
            end
            c = rand_ck ? ($urandom_range(0, 3) != 0) : 1'b1;
            ra = 8'hA0 + 8'(k);
            ga = 8'h50 + 8'(l);
            p = formula ? {ra, ga, 8'h0F} : 24'($urandom);
            step(0, 0, 1, c, p);
            if (c) k++;
         end
         if (merge && l == nlines - 1) begin
            step(0, 1, 0, 1'($urandom % 2), 24'($urandom));
            step(0, 1, 0, 0, 24'h0);
         end else begin
            // Strobes between lines must be ignored.
            repeat (3) step(0, 0, 0, 1'($urandom % 2), 24'($urandom));
         end
      end
      $display("frame %0d: lines=%0d bad_line=%0d bad_len=%0d rst_line=%0d merge=%0d",
               id, nlines, bad_line, bad_len, rst_line, merge);
   endtask

   // Monitor: compares at negedge against the inputs captured one negedge
   // earlier and against the scoreboard queues.
   initial begin
      bit         c_rst;
      bit         c_vs;
      bit         c_hs;
      bit         c_ck;
      bit         ele;
      bit         efe;
      logic [7:0] last0;
      logic [7:0] last3;
      logic [7:0] e;
      c_rst = 1; c_vs = 0; c_hs = 0; c_ck = 0; last0 = 8'h00; last3 = 8'h00;
      forever begin
         @(negedge clk);
         ele = (le_q.size() > 0 && le_q[0] == cyc);
         if (ele) void'(le_q.pop_front());
         efe = (fe_q.size() > 0 && fe_q[0] == cyc);
         if (efe) void'(fe_q.pop_front());
         if (c_rst) begin
            check("rst_out0", {26'd0, p0_vs, p0_hs, p0_ck, p0_le, p0_fe, 1'b0}, 32'd0);
            check("rst_raw0", 32'(p0_raw), 32'd0);
            check("rst_out3", {26'd0, p3_vs, p3_hs, p3_ck, p3_le, p3_fe, 1'b0}, 32'd0);
            check("rst_raw3", 32'(p3_raw), 32'd0);
            last0 = 8'h00;
            last3 = 8'h00;
         end else begin
            check("vsync0", 32'(p0_vs), 32'(c_vs));
            check("href0", 32'(p0_hs), 32'(c_hs));
            check("clken0", 32'(p0_ck), 32'(c_ck & c_hs));
            check("vsync3", 32'(p3_vs), 32'(c_vs));
            check("href3", 32'(p3_hs), 32'(c_hs));
            check("clken3", 32'(p3_ck), 32'(c_ck & c_hs));
            if (p0_ck) begin
               if (q0.size() == 0) check("raw0_extra", 32'd1, 32'd0);
               else begin
                  e = q0.pop_front();
                  check("raw0", 32'(p0_raw), 32'(e));
                  last0 = e;
               end
            end else check("raw0_hold", 32'(p0_raw), 32'(last0));
            if (p3_ck) begin
               if (q3.size() == 0) check("raw3_extra", 32'd1, 32'd0);
               else begin
                  e = q3.pop_front();
                  check("raw3", 32'(p3_raw), 32'(e));
                  last3 = e;
               end
            end else check("raw3_hold", 32'(p3_raw), 32'(last3));
            check("line_err0", 32'(p0_le), 32'(ele));
            check("frame_err0", 32'(p0_fe), 32'(efe));
            check("line_err3", 32'(p3_le), 32'(ele));
            check("frame_err3", 32'(p3_fe), 32'(efe));
         end
         c_rst = rst; c_vs = vs; c_hs = hs; c_ck = ck;
      end
   end

   // Stimulus sequence.
   initial begin
      repeat (3) step(1, 0, 0, 0, 24'h0);
      repeat (2) step(0, 0, 0, 0, 24'h0);
      // id nlines bad_line bad_len formula rand_ck rst_line merge skip_vs
      frame(1, V, -1, 0,    1, 0, -1, 0, 0);  // reference pattern, first vsync
      frame(2, V, -1, 0,    0, 1, -1, 0, 0);  // random data, gapped strobes
      frame(3, V,  2, 9,    0, 1, -1, 0, 0);  // short line
      frame(4, 7, -1, 0,    0, 1, -1, 0, 0);  // short frame
      frame(5, V,  2, 4100, 0, 0, -1, 0, 0);  // column counter saturation
      frame(6, V,  V-1, 9,  0, 1, -1, 1, 0);  // href fall coincides with vsync rise
      frame(7, V, -1, 0,    0, 1,  3, 0, 1);  // reset at row 3 column 5
      frame(8, V, -1, 0,    1, 0, -1, 0, 0);  // reference pattern after reset
      step(0, 1, 0, 0, 24'h0);
      step(0, 1, 0, 0, 24'h0);
      repeat (6) step(0, 0, 0, 0, 24'h0);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q3_drained", 32'(q3.size()), 32'd0);
      check("le_q_drained", 32'(le_q.size()), 32'd0);
      check("fe_q_drained", 32'(fe_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vip_rgb888_raw8.md
VIP_RGB888_RAW8 -- requirements
Module: vip_rgb888_raw8

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameter BAYER_PATTERN, default 0, with encoding 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-005 SHALL have port rst, input, 1 bit: reset.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port per_frame_vsync, input, 1 bit: frame sync, active high (VSYNC valid = 1).
REQ-008 SHALL have port per_frame_href, input, 1 bit: line valid, active high.
REQ-009 SHALL have port per_frame_clken, input, 1 bit: pixel strobe.
REQ-010 SHALL have port per_img_rgb888, input, 24 bits: R in [23:16], G in [15:8], B in [7:0].
REQ-011 SHALL have port post_frame_vsync, output, 1 bit: delayed vsync.
REQ-012 SHALL have port post_frame_href, output, 1 bit: delayed href.
REQ-013 SHALL have port post_frame_clken, output, 1 bit: output pixel strobe.
REQ-014 SHALL have port post_img_RAW, output, 8 bits: mosaiced Bayer sample.
REQ-015 SHALL have port line_len_err, output, 1 bit: one-cycle pulse when a line length is not IMG_HDISP.
REQ-016 SHALL have port frame_len_err, output, 1 bit: one-cycle pulse when a frame's line count is not IMG_VDISP.

Function
REQ-017 SHALL accept a pixel only in a cycle where per_frame_clken=1 and per_frame_href=1; a clken pulse while href=0 SHALL be ignored.
REQ-018 SHALL maintain a 12-bit column counter: +1 per accepted pixel, saturating at 4095, cleared on the href falling edge (href registered 1, current 0).
REQ-019 SHALL maintain a 12-bit row counter: +1 on each href falling edge, saturating at 4095.
REQ-020 SHALL clear the row counter and column counter on the vsync rising edge (vsync registered 0, current 1).
REQ-021 SHALL compute row parity rp = row[0] XOR BAYER_PATTERN[1] and column parity cp = col[0] XOR BAYER_PATTERN[0].
REQ-022 SHALL select the output sample from (rp,cp) as follows: (0,0)=R, (0,1)=G, (1,0)=G, (1,1)=B.
REQ-023 SHALL register the output with a fixed latency of 1 clk: post_frame_vsync, post_frame_href and post_img_RAW each equal the corresponding input-side value one cycle earlier.
REQ-024 SHALL drive post_frame_clken as (per_frame_clken AND per_frame_href) delayed by 1 cycle.
REQ-025 SHALL hold post_img_RAW at its last value in cycles with no accepted pixel.
REQ-026 SHALL pulse line_len_err for exactly one cycle, 1 cycle after an href falling edge, if the column count at that edge is not equal to IMG_HDISP.
REQ-027 SHALL pulse frame_len_err for exactly one cycle, 1 cycle after a vsync rising edge, if the row count is not equal to IMG_VDISP.
REQ-028 SHALL NOT pulse frame_len_err on the first vsync rising edge after reset, because no complete frame has been seen.
REQ-029 SHALL give a simultaneous vsync rising edge and href falling edge the following priority: vsync clears both counters, the line check is suppressed, and the frame check uses the row count before the increment.
REQ-030 SHALL use an "armed" flag, cleared by reset and set on the first vsync rising edge; while armed=0, both error outputs SHALL stay 0 and counters SHALL run, so that a partial frame after a mid-frame reset is never flagged.
REQ-031 SHALL compute the mosaic without arithmetic; the 24-bit to 8-bit path SHALL be a pure byte select.

Reset
REQ-032 SHALL, while rst=1, drive post_frame_vsync, post_frame_href, post_frame_clken, post_img_RAW (8'h00), line_len_err and frame_len_err to 0 on the next clk edge.
REQ-033 SHALL, while rst=1, drive the row counter, column counter, armed flag and href/vsync edge registers to 0 on the next clk edge.
REQ-034 SHALL, on rst asserted mid-line, show outputs at 0 at the first edge and keep them 0 until rst is released; the first accepted pixel after release SHALL be treated as row 0, column 0.

Verification
REQ-035 SHALL verify, with a 10x8 frame, BAYER_PATTERN=0 and pixel = {8'hA0+col, 8'h50+row, 8'h0F}: row 0 outputs A0,50,A2,50,...; row 1 outputs 51,0F,51,0F,...; latency is 1 clk; no error pulses.
REQ-036 SHALL verify that the same stimulus with BAYER_PATTERN=3 gives row 0 = 0F,50,0F,...; row 1 = 51,A1,51,A3,....
REQ-037 SHALL verify that a 9-pixel line inside an armed frame gives line_len_err=1 for exactly 1 cycle, 1 cycle after that href falls; the next 10-pixel line gives no pulse.
REQ-038 SHALL verify that a frame of 7 lines followed by a vsync rise gives frame_len_err=1 for one cycle; the first vsync after reset gives no pulse.
REQ-039 SHALL verify that clken toggling while href=0 gives post_frame_clken=0, leaves post_img_RAW unchanged and leaves the column counter unchanged.
REQ-040 SHALL verify that rst=1 asserted at column 5 of row 3 gives all outputs 0 on the next edge; after release, the next frame outputs the same as the first scenario with no error pulses.
